// File: rtl/seq_detector_pkg.sv
// Shared types and default constants for the parametrised sequence detector.
package seq_detector_pkg;

   typedef enum logic [1:0] {
      EMPTY   = 2'd0,
      FILLING = 2'd1,
      ARMED   = 2'd2
   } fill_state_e;

   localparam logic [1:0] SYM_A = 2'd1;
   localparam logic [1:0] SYM_B = 2'd2;
   localparam logic [1:0] SYM_C = 2'd3;

   // C,B,B,A,A with the first-arriving symbol in the low bits
   localparam logic [9:0] DEF_RESET_PATTERN = {SYM_A, SYM_A, SYM_B, SYM_B, SYM_C};

endpackage

// File: rtl/led_stretcher.sv
// Reloadable down-counter: led stays high for LED_HOLD cycles after the last trigger.
module led_stretcher #(
   parameter int LED_HOLD = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic i_trig,
   output logic o_led
);

   localparam int HW = $clog2(LED_HOLD + 1);

   logic [HW-1:0] r_cnt;
   logic          r_led;

   // led is registered alongside the reload so it rises on the trigger edge
   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt <= '0;
         r_led <= 1'b0;
      end else if (i_trig) begin
         r_cnt <= HW'(LED_HOLD);
         r_led <= 1'b1;
      end else begin
         r_cnt <= (r_cnt != '0) ? r_cnt - 1'b1 : r_cnt;
         r_led <= (r_cnt > HW'(1));
      end
   end

   assign o_led = r_led;

endmodule

// File: rtl/seq_detector_param.sv
// Programmable symbol-sequence detector with overlap mode and LED stretch.
// Optional saturating match counter built when SEQDET_MATCH_CNT_EN is defined.
module seq_detector_param
   import seq_detector_pkg::*;
#(
   parameter int                         SYM_W         = 2,
   parameter int                         SEQ_LEN       = 5,
   parameter logic [SEQ_LEN*SYM_W-1:0]   RESET_PATTERN = DEF_RESET_PATTERN,
   parameter int                         LED_HOLD      = 4,
   parameter int                         CNT_W         = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [SYM_W-1:0]           sym,
   input  logic                       sym_valid,
   input  logic                       overlap_en,
   input  logic                       cfg_we,
   input  logic [$clog2(SEQ_LEN)-1:0] cfg_idx,
   input  logic [SYM_W-1:0]           cfg_sym,
   output logic                       match,
   output logic                       led,
   output logic [CNT_W-1:0]           match_cnt
);

   localparam int IDX_W  = $clog2(SEQ_LEN);
   localparam int FILL_W = $clog2(SEQ_LEN + 1);
   localparam logic [FILL_W-1:0] FULL    = FILL_W'(SEQ_LEN);
   localparam logic [IDX_W:0]    IDX_LIM = (IDX_W + 1)'(SEQ_LEN);

   logic [SEQ_LEN-1:0][SYM_W-1:0] r_pat, r_hist;
   logic [FILL_W-1:0]             r_fill;
   logic                          r_match;

   logic [SEQ_LEN-1:0][SYM_W-1:0] w_pat_nxt, w_hist_nxt, w_shift;
   logic [FILL_W-1:0]             w_fill_nxt, w_fill_inc;
   logic                          w_match_nxt;
   fill_state_e                   w_state;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_pat   <= RESET_PATTERN;
         r_hist  <= '0;
         r_fill  <= '0;
         r_match <= 1'b0;
      end else begin
         r_pat   <= w_pat_nxt;
         r_hist  <= w_hist_nxt;
         r_fill  <= w_fill_nxt;
         r_match <= w_match_nxt;
      end
   end

   // Newest symbol lands in the top slot, so slot 0 lines up with pattern slot 0
   assign w_shift = {sym, r_hist[SEQ_LEN-1:1]};

   always_comb begin
      w_pat_nxt   = r_pat;
      w_hist_nxt  = r_hist;
      w_fill_nxt  = r_fill;
      w_match_nxt = 1'b0;
      w_state     = FILLING;
      if (r_fill == '0)        w_state = EMPTY;
      else if (r_fill == FULL) w_state = ARMED;
      w_fill_inc = (w_state == ARMED) ? r_fill : r_fill + 1'b1;

      if (cfg_we) begin
         w_fill_nxt = '0;
         if ({1'b0, cfg_idx} < IDX_LIM) w_pat_nxt[cfg_idx] = cfg_sym;
      end else if (sym_valid) begin
         w_hist_nxt = w_shift;
         w_fill_nxt = w_fill_inc;
         if (w_shift == r_pat && w_fill_inc == FULL) begin
            w_match_nxt = 1'b1;
            w_fill_nxt  = overlap_en ? FULL : '0;
         end
      end
   end

   assign match = r_match;

   led_stretcher #(.LED_HOLD(LED_HOLD)) u_led (
      .clk    (clk),
      .reset  (reset),
      .i_trig (w_match_nxt),
      .o_led  (led)
   );

`ifdef SEQDET_MATCH_CNT_EN
   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (reset)                         r_cnt <= '0;
      else if (w_match_nxt && r_cnt != '1) r_cnt <= r_cnt + 1'b1;
   end

   assign match_cnt = r_cnt;
`else
   assign match_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Self-checking bench: fixed vector table, directed corner sequences, random run vs. queue model.
module tb_seq_detector_param;

   localparam int SYM_W = 2, SEQ_LEN = 5, LED_HOLD = 4, CNT_W = 8;
   localparam int IW = $clog2(SEQ_LEN);
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             reset, sym_valid, overlap_en, cfg_we;
   logic [SYM_W-1:0] sym, cfg_sym;
   logic [IW-1:0]    cfg_idx;
   logic             match, led;
   logic [CNT_W-1:0] match_cnt;

   int checks = 0, errors = 0;

   int   m_pat[SEQ_LEN];
   int   m_q[$];
   int   m_fill, m_hold, m_cnt;
   logic m_match;

   typedef struct {
      logic       v;
      logic [1:0] s;
      logic       m;
      logic       l;
   } vec_t;
   vec_t tbl[10];

   seq_detector_param #(
      .SYM_W(SYM_W), .SEQ_LEN(SEQ_LEN), .LED_HOLD(LED_HOLD), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .reset(reset), .sym(sym), .sym_valid(sym_valid),
      .overlap_en(overlap_en), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_sym(cfg_sym),
      .match(match), .led(led), .match_cnt(match_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic model_reset();
      m_pat = '{3, 2, 2, 1, 1};
      m_q.delete();
      m_fill = 0; m_hold = 0; m_cnt = 0; m_match = 1'b0;
   endtask

   function automatic bit hist_eq();
      for (int i = 0; i < SEQ_LEN; i++) if (m_q[i] != m_pat[i]) return 0;
      return 1;
   endfunction

   // One clock edge of the reference behaviour, using the inputs held at that edge
   task automatic model_edge();
      m_match = 1'b0;
      if (reset) model_reset();
      else begin
         if (cfg_we) begin
            m_fill = 0;
            if (int'(cfg_idx) < SEQ_LEN) m_pat[cfg_idx] = int'(cfg_sym);
         end else if (sym_valid) begin
            m_q.push_back(int'(sym));
            if (m_q.size() > SEQ_LEN) void'(m_q.pop_front());
            if (m_fill < SEQ_LEN) m_fill++;
            if (m_fill == SEQ_LEN && hist_eq()) begin
               m_match = 1'b1;
               if (!overlap_en) m_fill = 0;
            end
         end
         if (m_match) begin
            m_hold = LED_HOLD;
`ifdef SEQDET_MATCH_CNT_EN
            if (m_cnt < CNT_MAX) m_cnt++;
`endif
         end else if (m_hold > 0) m_hold--;
      end
   endtask

   task automatic step(input logic v, input logic [1:0] s, input logic we,
                       input logic [IW-1:0] idx, input logic [1:0] cs, input logic ov);
      sym_valid = v; sym = s; cfg_we = we; cfg_idx = idx; cfg_sym = cs; overlap_en = ov;
      @(posedge clk);
      model_edge();
      #1;
      chk("match", match, m_match);
      chk("led", led, (m_hold > 0));
      chk("match_cnt", match_cnt, m_cnt);
   endtask

   task automatic sv(input logic [1:0] s, input logic ov);
      step(1'b1, s, 1'b0, '0, '0, ov);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step(1'b0, '0, 1'b0, '0, '0, 1'b0);
      reset = 1'b0;
   endtask

   task automatic write_ones();
      for (int i = 0; i < SEQ_LEN; i++) step(1'b0, '0, 1'b1, IW'(i), 2'd1, 1'b0);
   endtask

   int seen, led_low, exp_cnt;

   initial begin
      reset = 1'b1; sym_valid = 0; sym = 0; cfg_we = 0; cfg_idx = 0; cfg_sym = 0; overlap_en = 0;
      model_reset();
      tbl = '{'{1,3,0,0}, '{1,2,0,0}, '{1,2,0,0}, '{1,1,0,0}, '{1,1,1,1},
              '{0,0,0,1}, '{0,0,0,1}, '{0,0,0,1}, '{0,0,0,0}, '{0,0,0,0}};

      do_reset();
      chk("rst_match", match, 0);
      chk("rst_led", led, 0);
      chk("rst_cnt", match_cnt, 0);

      // Default pattern C,B,B,A,A against fixed expectations
      for (int i = 0; i < 10; i++) begin
         step(tbl[i].v, tbl[i].s, 1'b0, '0, '0, 1'b0);
         chk($sformatf("tbl%0d_match", i), match, tbl[i].m);
         chk($sformatf("tbl%0d_led", i), led, tbl[i].l);
      end
`ifdef SEQDET_MATCH_CNT_EN
      chk("tbl_cnt", match_cnt, 1);
`else
      chk("tbl_cnt", match_cnt, 0);
`endif

      // Overlapping: six 1s give two matches with led held continuously
      write_ones();
      seen = 0; led_low = 0;
      for (int i = 0; i < 6; i++) begin
         sv(2'd1, 1'b1);
         seen += int'(match);
         if (i >= 4 && !led) led_low++;
      end
      chk("ovl_matches", seen, 2);
      chk("ovl_led_cont", led_low, 0);

      // Non-overlapping: one match, the 6th symbol restarts fill at 1
      step(1'b0, '0, 1'b1, '0, 2'd1, 1'b0);
      seen = 0;
      for (int i = 0; i < 6; i++) begin sv(2'd1, 1'b0); seen += int'(match); end
      chk("novl_matches", seen, 1);
      for (int i = 0; i < 3; i++) begin sv(2'd1, 1'b0); seen += int'(match); end
      chk("novl_refill_early", seen, 1);
      sv(2'd1, 1'b0);
      chk("novl_refill_match", match, 1);

      // Idle gaps inside the sequence
      do_reset();
      sv(2'd3, 0); sv(2'd2, 0);
      for (int i = 0; i < 3; i++) step(1'b0, 2'd1, 1'b0, '0, '0, 1'b0);
      sv(2'd2, 0); sv(2'd1, 0); sv(2'd1, 0);
      chk("gap_match", match, 1);

      // Config write with an out-of-range slot drops the 4th symbol and clears fill
      sv(2'd3, 0); sv(2'd2, 0); sv(2'd2, 0);
      step(1'b1, 2'd1, 1'b1, IW'(7), 2'd0, 1'b0);
      sv(2'd1, 0);
      chk("cfg_drop_nomatch", match, 0);
      sv(2'd3, 0); sv(2'd2, 0); sv(2'd2, 0); sv(2'd1, 0); sv(2'd1, 0);
      chk("cfg_ignored_match", match, 1);

      // Reset mid-sequence discards progress
      sv(2'd3, 0); sv(2'd2, 0); sv(2'd2, 0); sv(2'd1, 0);
      do_reset();
      sv(2'd1, 0);
      chk("midrst_nomatch", match, 0);

      // Counter saturation
      do_reset();
      write_ones();
      for (int i = 0; i < 304; i++) sv(2'd1, 1'b1);
`ifdef SEQDET_MATCH_CNT_EN
      exp_cnt = CNT_MAX;
`else
      exp_cnt = 0;
`endif
      chk("cnt_sat", match_cnt, exp_cnt);

      // Random traffic with a 0/1-heavy alphabet so matches occur often
      do_reset();
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 39) == 0)
            step($urandom_range(0, 1), 2'($urandom_range(0, 3)), 1'b1,
                 IW'($urandom_range(0, 7)), 2'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         else if ($urandom_range(0, 299) == 0)
            do_reset();
         else
            step($urandom_range(0, 3) != 0, 2'($urandom_range(0, 9) == 0 ? 3 : $urandom_range(0, 1)),
                 1'b0, '0, '0, 1'($urandom_range(0, 1)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
